// File: rtl/rr_arbiter_2x1.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2x1
// Two-input round-robin arbiter with bounded-burst locking and a one-entry
// registered output stage. It drives the downstream 2:1 mux select (sel)
// together with the registered data word.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in0_valid  in   source 0 has data
//   in0_data   in   source 0 data [WIDTH]
//   in0_ready  out  source 0 beat accepted (with in0_valid)
//   in1_valid  in   source 1 has data
//   in1_data   in   source 1 data [WIDTH]
//   in1_ready  out  source 1 beat accepted (with in1_valid)
//   out_valid  out  output register holds a beat
//   out_data   out  registered forwarded data [WIDTH]
//   out_ready  in   downstream accepts beat
//   sel        out  registered source index of out_data
// ---------------------------------------------------------------------------
module rr_arbiter_2x1 #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_sel;

  logic             w_load_en;
  logic [1:0]       w_vld;
  logic             w_gnt_vld;
  logic             w_gnt;
  logic             w_burst_open;

  assign w_load_en    = !r_out_valid || out_ready;
  assign w_vld        = {in1_valid, in0_valid};
  assign w_burst_open = (r_cnt < C_MAX_BURST);

  // Grant selection: an open lock keeps its source, otherwise the source
  // that was not served last wins, falling back to the last-served source.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = 1'b0;
    if (w_load_en) begin
      if (r_state == ST_LOCK0 && in0_valid && w_burst_open) begin
        w_gnt_vld = 1'b1;
        w_gnt     = 1'b0;
      end else if (r_state == ST_LOCK1 && in1_valid && w_burst_open) begin
        w_gnt_vld = 1'b1;
        w_gnt     = 1'b1;
      end else if (w_vld[~r_last]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = ~r_last;
      end else if (w_vld[r_last]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = r_last;
      end else begin
        w_gnt_vld = 1'b0;
        w_gnt     = 1'b0;
      end
    end else begin
      w_gnt_vld = 1'b0;
      w_gnt     = 1'b0;
    end
  end

  // A grant is only ever issued to a valid source, so a grant is a transfer.
  // Readies are forced low while reset is held.
  assign in0_ready = !rst && w_gnt_vld && !w_gnt;
  assign in1_ready = !rst && w_gnt_vld &&  w_gnt;

  // Lock state, burst counter and last-served source; all hold on a stall
  // so a lock survives back-pressure.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    if (w_load_en) begin
      if (w_gnt_vld) begin
        w_last_nxt  = w_gnt;
        w_state_nxt = w_gnt ? ST_LOCK1 : ST_LOCK0;
        if (r_state == (w_gnt ? ST_LOCK1 : ST_LOCK0) && w_burst_open) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end else begin
          // new burst, including re-grant of the same source after expiry
          w_cnt_nxt = 4'd1;
        end
      end else if (!in0_valid && !in1_valid) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end else begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
      end
    end else begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_last_nxt  = r_last;
    end
  end

  // State register; last resets to 1 so source 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Output stage: load on transfer, drop valid on a pop without a reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sel       <= 1'b0;
    end else if (w_gnt_vld) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt ? in1_data : in0_data;
      r_sel       <= w_gnt;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sel       = r_sel;

endmodule

// File: tb/tb_rr_arbiter_2x1.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_2x1
// Directed bench for rr_arbiter_2x1. Instance a uses MAX_BURST=4, instance b
// uses MAX_BURST=1; both share the input stimulus.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_2x1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid, in1_valid, out_ready;
  logic [7:0] in0_data, in1_data;

  logic       a_in0_ready, a_in1_ready, a_out_valid, a_sel;
  logic [7:0] a_out_data;
  logic       b_in0_ready, b_in1_ready, b_out_valid, b_sel;
  logic [7:0] b_out_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] ptr0, ptr1;
  logic       acc0, acc1;

  logic [7:0] exp_c [0:15] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83,
                               8'h04, 8'h05, 8'h06, 8'h07, 8'h84, 8'h85, 8'h86, 8'h87};

  always #5 clk = ~clk;

  rr_arbiter_2x1 #(.WIDTH(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(a_in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(a_in1_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready),
    .sel(a_sel)
  );

  rr_arbiter_2x1 #(.WIDTH(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(b_in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(b_in1_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
    .sel(b_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One contention beat on instance a with both sources valid.
  task automatic beat(input string tag, input logic [7:0] exp_data);
    in0_data = ptr0;
    in1_data = 8'h80 | ptr1;
    #1;
    acc0 = a_in0_ready;
    acc1 = a_in1_ready;
    check({tag, "_not_both_ready"}, 32'(acc0 & acc1), 32'd0);
    cyc();
    check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
    check({tag, "_data"}, 32'(a_out_data), 32'(exp_data));
    check({tag, "_sel"}, 32'(a_sel), 32'(exp_data[7]));
    if (acc0) ptr0 = ptr0 + 8'd1;
    if (acc1) ptr1 = ptr1 + 8'd1;
  endtask

  initial begin
    rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00;
    ptr0 = 8'h00; ptr1 = 8'h00;
    #12;
    check("rst_valid", 32'(a_out_valid), 32'd0);
    check("rst_data", 32'(a_out_data), 32'd0);
    check("rst_sel", 32'(a_sel), 32'd0);
    check("rst_cnt", 32'(dut_a.r_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single source streaming
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h11;
    #1;
    check("ss_rdy0", 32'(a_in0_ready), 32'd1);
    check("ss_rdy1", 32'(a_in1_ready), 32'd0);
    cyc();
    check("ss_d11", 32'(a_out_data), 32'h11);
    check("ss_v11", 32'(a_out_valid), 32'd1);
    check("ss_s11", 32'(a_sel), 32'd0);
    in0_data = 8'h22;
    cyc();
    check("ss_d22", 32'(a_out_data), 32'h22);
    check("ss_v22", 32'(a_out_valid), 32'd1);
    in0_data = 8'h33;
    cyc();
    check("ss_d33", 32'(a_out_data), 32'h33);
    check("ss_s33", 32'(a_sel), 32'd0);
    in0_valid = 1'b0;
    cyc();
    check("ss_drain", 32'(a_out_valid), 32'd0);

    // reset mid-stream with a held beat
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_data = 8'hA5;
    cyc();
    in0_valid = 1'b0;
    check("mr_pre_data", 32'(a_out_data), 32'hA5);
    check("mr_pre_valid", 32'(a_out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_valid", 32'(a_out_valid), 32'd0);
    check("mr_data", 32'(a_out_data), 32'd0);
    check("mr_sel", 32'(a_sel), 32'd0);
    out_ready = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    #1;
    check("mr_rdy0", 32'(a_in0_ready), 32'd0);
    check("mr_rdy1", 32'(a_in1_ready), 32'd0);
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // contention, both sources always valid
    in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat($sformatf("ct%0d", i), exp_c[i]);
    end
    beat("ct16", 8'h08);
    beat("ct17", 8'h09);
    beat("ct18", 8'h0A);
    beat("ct19", 8'h0B);
    beat("bp_b1", 8'h88);
    beat("bp_b2", 8'h89);

    // back-pressure during the 2nd beat of an in1 burst
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rdy0", 32'(a_in0_ready), 32'd0);
      check("bp_rdy1", 32'(a_in1_ready), 32'd0);
      cyc();
      check("bp_hold_data", 32'(a_out_data), 32'h89);
      check("bp_hold_sel", 32'(a_sel), 32'd1);
    end
    out_ready = 1'b1;
    beat("bp_b3", 8'h8A);
    beat("bp_b4", 8'h8B);
    beat("bp_next0", 8'h0C);

    // simultaneous pop and load
    in1_valid = 1'b0;
    in0_data = 8'h5C;
    #1;
    check("pl_rdy0", 32'(a_in0_ready), 32'd1);
    cyc();
    check("pl_valid", 32'(a_out_valid), 32'd1);
    check("pl_data", 32'(a_out_data), 32'h5C);
    in0_valid = 1'b0;
    cyc();
    check("pl_drain", 32'(a_out_valid), 32'd0);

    // burst re-arm on the MAX_BURST=1 instance
    rst = 1'b1;
    #3;
    rst = 1'b0;
    @(negedge clk);
    in1_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in1_data = 8'h41 + 8'(i);
      #1;
      check("ra_rdy1", 32'(b_in1_ready), 32'd1);
      cyc();
      check("ra_data", 32'(b_out_data), 32'(8'h41 + 8'(i)));
      check("ra_sel", 32'(b_sel), 32'd1);
      check("ra_cnt", 32'(dut_b.r_cnt), 32'd1);
      check("ra_state", 32'(dut_b.r_state), 32'd2);
    end
    in1_valid = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_2x1.md
# rr_arbiter_2x1

Two-input round-robin arbiter with valid/ready handshakes and a one-entry registered output stage. It sits directly upstream of the 2:1 multiplexer datapath. It decides which of two sources is forwarded and drives the mux select `sel` together with the registered data word. Arbitration uses bounded-burst locking, so one source can stream up to `MAX_BURST` consecutive beats before the other is served.

## Interface
Parameters:
- `WIDTH`, 8: data width of each channel.
- `MAX_BURST`, 4: maximum consecutive beats granted to one source while the other is waiting; legal range 1..15.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in0_valid`  input  1  source 0 has data.
- `in0_data`  input  WIDTH  source 0 data.
- `in0_ready`  output  1  source 0 beat accepted this cycle when high with `in0_valid`.
- `in1_valid`  input  1  source 1 has data.
- `in1_data`  input  WIDTH  source 1 data.
- `in1_ready`  output  1  source 1 beat accepted this cycle when high with `in1_valid`.
- `out_valid`  output  1  output register holds a beat.
- `out_data`  output  WIDTH  registered forwarded data.
- `out_ready`  input  1  downstream accepts beat.
- `sel`  output  1  registered source index of the beat in `out_data` (0 = in0, 1 = in1); drives downstream mux select.

## Operation
- `load_en = !out_valid || out_ready`. The output register may load only when `load_en` is high.
- Grant `g` is evaluated combinationally each cycle, and only when `load_en` is high:
  - If state is LOCKx, `inx_valid` is high and `cnt < MAX_BURST`: grant x.
  - Otherwise, grant the source other than `last` if it is valid. Failing that, grant `last` if it is valid. Failing that, no grant.
- `ing_ready = load_en` for the granted source only. The non-granted source always sees ready low.
- A transfer occurs when the granted source has valid high and ready high. On transfer:
  - `out_data <= ing_data`, `sel <= g`, `out_valid <= 1`, `last <= g`.
- A downstream pop is `out_valid && out_ready`. On a pop with no simultaneous transfer, `out_valid <= 0`; `out_data` and `sel` hold their values.
- A pop and a transfer in the same cycle are legal. The register is replaced and `out_valid` stays 1.
- State machine: IDLE, LOCK0, LOCK1, plus a burst counter `cnt` (4 bits).
  - Transfer from g while in LOCKg with `cnt < MAX_BURST`: stay in LOCKg, `cnt <= cnt+1`.
  - Transfer from g in any other case (IDLE, LOCK of the other source, or `cnt == MAX_BURST`): go to LOCKg, `cnt <= 1`.
  - `load_en` high with neither input valid: go to IDLE, `cnt <= 0`.
  - `load_en` low (stall): state, `cnt` and `last` hold, so the lock survives back-pressure.
- If `cnt == MAX_BURST` and the other source is idle, the same source is re-granted and starts a new burst (`cnt = 1`).
- Reset (asynchronous, any time, including mid-burst or with `out_valid` high):
  - `out_valid = 0`, `out_data = 0`, `sel = 0`.
  - State IDLE, `cnt = 0`, `last = 1`, so source 0 wins the first contention.
  - `in0_ready` and `in1_ready` are 0 while `rst` is high.
  - Any beat pending in the output register is discarded.

## Timing
- Latency: a beat accepted at edge N appears on `out_data`/`out_valid`/`sel` immediately after edge N. That is one cycle of latency.
- Throughput: one beat per cycle when `out_ready` is held high.
- Combinational paths:
  - `out_ready` → `inX_ready`.
  - `inX_valid` → `inY_ready`.
  - No path from `inX_data` to any output except through the register.
- `sel` and `out_data` always change on the same edge.
- The `ready` outputs never depend on the `data` inputs.
- Handshake rules on inputs:
  - Sources must hold `valid` and `data` stable until accepted.
  - The arbiter never asserts ready for both sources in the same cycle.

## Test plan
- Reset mid-stream: `out_valid = 1`, `out_data = 8'hA5`; assert `rst` between edges → `out_valid`, `out_data`, `sel` go to 0 immediately without waiting for an edge; both readies are 0 while `rst` is high.
- Single source, `out_ready = 1`: in0 sends 8'h11, 8'h22, 8'h33 on consecutive cycles → the same values appear on `out_data` one cycle later each, with `sel = 0`, no bubbles and no re-ordering.
- Contention, `MAX_BURST = 4`, both sources always valid, `out_ready = 1`:
  - Sequence: in0 data 0x00..0x07, in1 data 0x80..0x87.
  - Required output: 00,01,02,03,80,81,82,83,04,05,06,07,84,…
  - `sel` sequence: 0,0,0,0,1,1,1,1,0,…
- Back-pressure: during the 2nd beat of an in1 burst, hold `out_ready = 0` for 3 cycles → `out_data` and `sel` hold; both readies are low; after release, in1 completes its remaining beats (4 in total) before in0 is served.
- Simultaneous pop and load: `out_valid = 1`, `out_ready = 1`, in0 valid with 8'h5C → `out_valid` stays 1, `out_data` becomes 8'h5C on the next edge, and the old beat is counted exactly once.
- Burst re-arm: `MAX_BURST = 1`, only in1 valid for 3 beats → all 3 are accepted back to back with `sel = 1`; the state remains LOCK1 with `cnt = 1` after each transfer.
